// File: rtl/laser_mem_sched.sv
// Four-slot time-division scheduler sharing one single-port RAM between video fetch, ioctl download and the Z80.
// Optional macro DL_HOLD_CPU_EN: stalls the CPU during a download and hands slots 1-3 to the download FIFO.
module laser_mem_sched #(
    parameter int          AW         = 18,
    parameter int          DW         = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  DL_INDEX   = 8'h00,
    parameter int unsigned DL_BASE    = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    // video
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    // cpu: cpu_req is a level held until cpu_ack; cpu_ack pulses once per served request
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    // ioctl download
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    output logic          dl_done,
    output logic          dl_overflow,
    // ram
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int            CW       = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] BASE_A   = AW'(DL_BASE);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW:0]   CNT_ONE  = (CW+1)'(1);
    localparam logic [CW-1:0] PTR_ONE  = CW'(1);

    logic [1:0]    slot;
    logic [1:0]    slot_nxt;
    logic [CW:0]   count;
    logic [CW:0]   count_nxt;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];

    logic dl_accept, fifo_empty, fifo_full;
    logic hold_cpu, dl_slot;
    logic pop, push, drop;
    logic vid_go, cpu_go;
    logic vid_rd;
    logic cpu_pending, cpu_pending_rd, cpu_ack_rd;
    logic dl_prev, dl_active;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ioctl_addr[24:AW]};

    assign slot_nxt   = slot + 2'd1;
    assign dl_accept  = ioctl_wr && ioctl_download && (ioctl_index == DL_INDEX);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);

`ifdef DL_HOLD_CPU_EN
    assign hold_cpu = ioctl_download || !fifo_empty;
    assign dl_slot  = (slot_nxt != 2'd0);
`else
    assign hold_cpu = 1'b0;
    assign dl_slot  = (slot_nxt == 2'd2);
`endif

    // Slot ownership for the cycle being entered: video, then download, then CPU.
    assign vid_go = (slot_nxt == 2'd0);
    assign pop    = !vid_go && dl_slot && !fifo_empty;
    assign push   = dl_accept && (!fifo_full || pop);
    assign drop   = dl_accept && fifo_full && !pop;
    assign cpu_go = !vid_go && !pop && cpu_req && !cpu_pending && !hold_cpu;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    // RAM data arrives one cycle after the address, so read results are steered straight from mem_dout.
    assign vid_data  = vid_valid  ? mem_dout : '0;
    assign cpu_rdata = cpu_ack_rd ? mem_dout : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr[AW-1:0] + BASE_A;
            fifo_data[wr_ptr] <= DW'(ioctl_dout);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot           <= 2'd0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            mem_din        <= '0;
            vid_rd         <= 1'b0;
            vid_valid      <= 1'b0;
            cpu_pending    <= 1'b0;
            cpu_pending_rd <= 1'b0;
            cpu_ack        <= 1'b0;
            cpu_ack_rd     <= 1'b0;
            ioctl_wait     <= 1'b0;
            dl_overflow    <= 1'b0;
            dl_prev        <= 1'b0;
            dl_active      <= 1'b0;
            dl_done        <= 1'b0;
        end else begin
            slot <= slot_nxt;

            if (vid_go) begin
                mem_addr <= vid_addr;
                mem_we   <= 1'b0;
            end else if (pop) begin
                mem_addr <= fifo_addr[rd_ptr];
                mem_din  <= fifo_data[rd_ptr];
                mem_we   <= 1'b1;
            end else if (cpu_go) begin
                mem_addr <= cpu_addr;
                mem_din  <= cpu_wdata;
                mem_we   <= cpu_we;
            end else begin
                mem_we   <= 1'b0;
            end

            vid_rd    <= vid_go;
            vid_valid <= vid_rd;

            // cpu_pending covers the access cycle; a request seen during the ack cycle is new.
            cpu_pending    <= cpu_go;
            cpu_pending_rd <= cpu_go && !cpu_we;
            cpu_ack        <= cpu_pending;
            cpu_ack_rd     <= cpu_pending_rd;

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count      <= count_nxt;
            ioctl_wait <= (count_nxt >= DEPTH_C - CNT_ONE);

            dl_prev <= ioctl_download;
            if (ioctl_download && !dl_prev)
                dl_overflow <= 1'b0;
            if (drop)
                dl_overflow <= 1'b1;

            dl_done <= 1'b0;
            if (ioctl_download)
                dl_active <= 1'b1;
            else if (dl_active && (count_nxt == '0)) begin
                dl_done   <= 1'b1;
                dl_active <= 1'b0;
            end
        end
    end

`ifdef DL_HOLD_CPU_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cpu_wait <= 1'b0;
        else
            cpu_wait <= ioctl_download || (count_nxt != '0);
    end
`else
    assign cpu_wait = 1'b0;
`endif

endmodule

// File: tb/tb_laser_mem_sched.sv
// Scoreboard bench for laser_mem_sched: behavioural RAM, reference memory and expected-result queues.
module tb_laser_mem_sched;

  localparam int AW    = 18;
  localparam int DEPTH = 4;
  localparam int BASE  = 'h20000;
`ifdef DL_HOLD_CPU_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [AW-1:0] vid_addr = '0;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic [7:0]    ioctl_index = '0;
  logic          ioctl_wait;
  logic          dl_done;
  logic          dl_overflow;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = '0;

  logic [7:0] ram     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  logic [7:0] vid_exp_q[$];
  logic [8:0] cpu_exp_q[$];
  logic [8:0] cpu_e;

  int total = 0;
  int bad = 0;
  int tb_slot = 0;
  int cyc = 0;
  int dl_done_cnt = 0;
  int done_cyc = 0;
  int ack_cyc = 0;
  bit vid_armed = 1'b0;
  bit saw_wait = 1'b0;

  laser_mem_sched #(
    .AW(AW), .DW(8), .FIFO_DEPTH(DEPTH), .DL_INDEX(8'h00), .DL_BASE(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .dl_done(dl_done), .dl_overflow(dl_overflow),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // clock / reset-side bookkeeping
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      tb_slot = 0;
      vid_armed = 1'b0;
      vid_exp_q.delete();
    end else begin
      tb_slot = (tb_slot + 1) % 4;
      if (tb_slot == 0) begin
        vid_exp_q.push_back(ref_mem[vid_addr]);
        vid_armed = 1'b1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop on DUT output
  always @(negedge clk) begin
    if (!reset_n) begin
      vid_armed = 1'b0;
      vid_exp_q.delete();
    end else begin
      if (ioctl_wait) saw_wait = 1'b1;
      if (dl_done) begin
        dl_done_cnt++;
        done_cyc = cyc;
      end
      check_val("vid_valid", vid_valid, (tb_slot == 1 && vid_armed));
      if (vid_valid) begin
        if (vid_exp_q.size() == 0) check_val("vid_extra", vid_valid, 0);
        else check_val("vid_data", vid_data, vid_exp_q.pop_front());
      end
      if (cpu_ack) begin
        ack_cyc = cyc;
        if (cpu_exp_q.size() == 0) check_val("cpu_ack_extra", cpu_ack, 0);
        else begin
          cpu_e = cpu_exp_q.pop_front();
          if (cpu_e[8]) check_val("cpu_rdata", cpu_rdata, cpu_e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_slot0();
    for (int k = 0; k < 4 && tb_slot != 0; k++) tick();
  endtask

  task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [7:0] d, output int lat);
    bit got;
    got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) begin
      ref_mem[a] = d;
      cpu_exp_q.push_back({1'b0, 8'h00});
    end else begin
      cpu_exp_q.push_back({1'b1, ref_mem[a]});
    end
    lat = 0;
    while (!got && lat < 300) begin
      tick();
      lat++;
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    check_val("cpu_ack_seen", got, 1);
  endtask

  task automatic dl_burst(input logic [7:0] idx, input int off, input int n, input bit force_wr,
                          output int n_drop);
    int i, guard, cnt, nslot;
    bit pop, acc;
    logic [7:0] dat;
    logic [AW-1:0] a;
    i = 0; guard = 0; cnt = 0; n_drop = 0;
    while (i < n && guard < 400) begin
      guard++;
      nslot = (tb_slot + 1) % 4;
      pop = (cnt > 0) && (nslot == 2 || (HOLD && nslot != 0));
      acc = 1'b0;
      if (force_wr || !ioctl_wait) begin
        dat = 8'($urandom_range(0, 255));
        a = AW'(off + i + BASE);
        ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = 25'(off + i); ioctl_dout = dat;
        if (idx == 8'h00) begin
          acc = (cnt < DEPTH) || pop;
          if (acc) ref_mem[a] = dat;
          else n_drop++;
        end
        i++;
      end else begin
        ioctl_wr = 1'b0;
      end
      cnt = cnt + int'(acc) - int'(pop);
      tick();
    end
    ioctl_wr = 1'b0;
    check_val("dl_burst_len", i, n);
  endtask

  task automatic end_download(input int exp_n);
    dl_done_cnt = 0;
    ioctl_download = 1'b0;
    repeat (40) tick();
    check_val("dl_done_cnt", dl_done_cnt, exp_n);
  endtask

  task automatic check_ram(input int off, input int n);
    for (int i = 0; i < n; i++)
      check_val("ram_dl", ram[AW'(off + i + BASE)], ref_mem[AW'(off + i + BASE)]);
  endtask

  task automatic check_zero();
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_din", mem_din, 0);
    check_val("rst_vid_valid", vid_valid, 0);
    check_val("rst_vid_data", vid_data, 0);
    check_val("rst_cpu_ack", cpu_ack, 0);
    check_val("rst_cpu_rdata", cpu_rdata, 0);
    check_val("rst_cpu_wait", cpu_wait, 0);
    check_val("rst_ioctl_wait", ioctl_wait, 0);
    check_val("rst_dl_done", dl_done, 0);
    check_val("rst_dl_overflow", dl_overflow, 0);
  endtask

  initial begin
    int lat, n_drop;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'($urandom_range(0, 255));
      ref_mem[i] = ram[i];
    end
    ram[18'h01234] = 8'hA5; ref_mem[18'h01234] = 8'hA5;
    ram[18'h00100] = 8'h3C; ref_mem[18'h00100] = 8'h3C;
    vid_addr = 18'h01234;

    #2 reset_n = 1'b0;
    repeat (3) tick();
    check_zero();
    reset_n = 1'b1;
    repeat (12) tick();

    // CPU read raised in slot 0: access slot 1, ack slot 2
    wait_slot0();
    cpu_access(1'b0, 18'h00100, 8'h00, lat);
    check_val("cpu_rd_latency", lat, 2);
    repeat (6) tick();

    cpu_access(1'b1, 18'h00200, 8'h77, lat);
    check_val("cpu_wr_lat_max", lat <= 4, 1);
    tick();
    cpu_access(1'b0, 18'h00200, 8'h00, lat);
    check_val("cpu_ram_wr", ram[18'h00200], 8'h77);
    repeat (4) tick();

    // 16-byte download honouring ioctl_wait
    saw_wait = 1'b0;
    ioctl_download = 1'b1;
    dl_burst(8'h00, 0, 16, 1'b0, n_drop);
    check_val("dl_saw_wait", saw_wait, 1);
    end_download(1);
    check_ram(0, 16);
    check_val("dl_ovf_clean", dl_overflow, 0);

    vid_addr = 18'h01235;

    // CPU concurrent with a download
    fork
      begin
        ioctl_download = 1'b1;
        dl_burst(8'h00, 'h40, 8, 1'b0, n_drop);
        end_download(1);
      end
      begin
        repeat (3) tick();
        check_val("cpu_wait_dl", cpu_wait, HOLD);
        cpu_access(1'b0, 18'h00300, 8'h00, lat);
        if (HOLD) begin
          check_val("hold_ack_after_drain", ack_cyc > done_cyc, 1);
          check_val("hold_ack_within_4", ack_cyc - done_cyc <= 4, 1);
        end else begin
          check_val("cpu_lat_concurrent", lat <= 4, 1);
        end
      end
    join
    check_ram('h40, 8);

    // writes to a foreign index are ignored
    ioctl_download = 1'b1;
    dl_burst(8'h01, 'h30, 4, 1'b0, n_drop);
    check_val("idx1_no_wait", ioctl_wait, 0);
    end_download(1);
    check_ram('h30, 4);

    // forced writes until full
    ioctl_download = 1'b1;
    dl_burst(8'h00, 'h100, 10, 1'b1, n_drop);
    if (!HOLD) check_val("ovf_model_drops", n_drop > 0, 1);
    check_val("ovf_set", dl_overflow, n_drop > 0);
    end_download(1);
    check_ram('h100, 10);
    check_val("ovf_sticky", dl_overflow, n_drop > 0);
    ioctl_download = 1'b1;
    tick();
    check_val("ovf_cleared", dl_overflow, 0);

    // reset in the middle of an overflowing download
    dl_burst(8'h00, 'h200, 10, 1'b1, n_drop);
    check_val("ovf_pre_reset", dl_overflow, n_drop > 0);
    ioctl_wr = 1'b1; ioctl_index = 8'h00; ioctl_addr = 25'h0300; ioctl_dout = 8'h11;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_zero();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    dl_done_cnt = 0;
    repeat (20) tick();
    check_val("no_dl_done_after_rst", dl_done_cnt, 0);

    check_val("cpu_q_empty", cpu_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/laser_mem_sched.md
Name: laser_mem_sched

Overview:
- Time-slot scheduler sharing one synchronous single-port system RAM between three requesters:
  - video fetch;
  - ioctl ROM/file download;
  - Z80 CPU.
- Sits between the laser500 core's bus and the RAM macro, on the 48 MHz system clock.
- Download writes are buffered in a small FIFO, with backpressure through ioctl_wait, so the video slot is never missed.

Parameters:
- AW, 18, RAM address width.
- DW, 8, data width.
- FIFO_DEPTH, 4, download FIFO entries (power of two, ≥2).
- DL_INDEX, 8'h00, ioctl_index value routed to RAM.
- DL_BASE, 0, RAM offset added to ioctl_addr.

Ports:
- clk  in  1  48 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- vid_addr  in  AW  video fetch address, sampled at slot 0.
- vid_data  out  DW  fetched video byte.
- vid_valid  out  1  one-cycle pulse, vid_data valid.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait  out  1  CPU stall request.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- ioctl_index  in  8  download target index.
- ioctl_wait  out  1  backpressure to loader.
- dl_done  out  1  one-cycle pulse: download ended and FIFO drained.
- dl_overflow  out  1  sticky: write arrived while FIFO full.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_din  out  DW  RAM write data.
- mem_dout  in  DW  RAM read data, one cycle after address.

Behaviour:
- Reset (async assert, sync release): slot=0, FIFO empty; every output 0, including mem_*, ioctl_wait, cpu_wait, dl_overflow.
- Slot counter: 2 bits, increments every clk, wraps 3→0. One RAM access per cycle; owner is registered on the edge entering the slot.
  - Slot 0: video read at vid_addr. vid_data = mem_dout and vid_valid=1 in the following cycle (slot 1).
  - Slot 2: download write if FIFO non-empty (pop one entry, mem_we=1); otherwise a CPU slot.
  - Slots 1, 3 (and an idle slot 2): CPU if cpu_req && !cpu_ack_pending.
    - Write: mem_we=1; cpu_ack pulses the next cycle.
    - Read: cpu_rdata=mem_dout and cpu_ack=1 the next cycle.
  - No owner: mem_we=0; mem_addr holds its previous value.
- CPU worst-case latency: 3 cycles from request to access, plus 1 to ack. The same request is never served twice: a request observed in the ack cycle is a new request.
- Accept rule: ioctl_wr && ioctl_download && ioctl_index==DL_INDEX.
  - Push {(ioctl_addr[AW-1:0]+DL_BASE) mod 2^AW, ioctl_dout}.
  - Writes with any other index are ignored.
- Backpressure: ioctl_wait is registered, =1 when count ≥ FIFO_DEPTH-1 after the current push/pop.
- Push and pop in the same cycle: count unchanged, both performed.
- Push when full and no pop: byte dropped, dl_overflow set. It clears only on reset or on a rising edge of ioctl_download.
- dl_done: pulses once, in the first cycle where ioctl_download=0, the FIFO is empty, and a download has been active since the last dl_done.
- Reset mid-download: FIFO contents discarded, no dl_done.
- cpu_wait: 0 unless DL_HOLD_CPU_EN.

Optional Feature:
- DL_HOLD_CPU_EN defined:
  - cpu_wait=1 while ioctl_download=1 or the FIFO is non-empty.
  - CPU is granted no slots in that period.
  - Download gets slots 1, 2, 3, i.e. up to 3 pops per 4 cycles.
- Undefined: cpu_wait tied 0; download owns slot 2 only; the CPU runs concurrently.

Test Plan:
- Reset released, vid_addr=0x1234, RAM[0x1234]=0xA5 → vid_valid pulses in slot 1 with vid_data=0xA5, every 4 cycles.
- CPU read cpu_addr=0x00100 (RAM=0x3C), request raised at slot 0 → access in slot 1, cpu_ack+cpu_rdata=0x3C in slot 2, single pulse only.
- Download of 16 bytes, one ioctl_wr every cycle, DL_BASE=0x20000 → ioctl_wait asserts when count reaches 3; RAM 0x20000..0x2000F match; dl_done pulses once after ioctl_download falls; dl_overflow=0.
- ioctl_wr with ioctl_index=0x01 → no FIFO push, no RAM write.
- Force writes ignoring ioctl_wait until full → dl_overflow=1 and dropped byte absent; next download start clears it. Then assert reset_n=0 mid-download → all outputs 0, no dl_done.
- DL_HOLD_CPU_EN build: cpu_req during download → cpu_wait=1, no cpu_ack until the FIFO drains; then ack within 4 cycles.
